// File: rtl/pe_driver.sv
// Sequences one MAC job through an external processing element: it fetches
// operand pairs, issues them with the running sum and collects each result.
module pe_driver #(
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [2*WIDTH-1:0]   bias,
    output logic                 busy,
    input  logic [WIDTH-1:0]     s_data,
    input  logic [WIDTH-1:0]     s_weight,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [WIDTH-1:0]     pe_data,
    output logic [WIDTH-1:0]     pe_weight,
    output logic [2*WIDTH-1:0]   pe_psum,
    output logic                 pe_data_update,
    output logic                 pe_weight_update,
    output logic                 pe_psum_update,
    input  logic [2*WIDTH-1:0]   pe_out_psum,
    input  logic                 pe_out_psum_vld,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_vld,
    output logic                 err
);
    localparam int PW = 2 * WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  cnt_inc;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     result_q, result_d;
    logic [WIDTH-1:0]  pe_data_q, pe_data_d;
    logic [WIDTH-1:0]  pe_weight_q, pe_weight_d;
    logic [PW-1:0]     pe_psum_q, pe_psum_d;
    logic              upd_q, upd_d;
    logic              err_q, err_d;

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        acc_d       = acc_q;
        result_d    = result_q;
        pe_data_d   = pe_data_q;
        pe_weight_d = pe_weight_q;
        pe_psum_d   = pe_psum_q;
        upd_d       = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = len;
                    acc_d = bias;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (len == '0) begin
                        state_d  = DONE;
                        result_d = bias;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (s_valid) begin
                    pe_data_d   = s_data;
                    pe_weight_d = s_weight;
                    pe_psum_d   = acc_q;
                    upd_d       = 1'b1;
                    tmo_d       = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // A result on the final timeout cycle still counts as on time
                if (pe_out_psum_vld) begin
                    acc_d = pe_out_psum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d  = DONE;
                        result_d = pe_out_psum;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A PE result outside WAIT is a protocol error and is otherwise dropped
        if (pe_out_psum_vld && (state_q != WAIT)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            pe_data_q   <= '0;
            pe_weight_q <= '0;
            pe_psum_q   <= '0;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            pe_data_q   <= pe_data_d;
            pe_weight_q <= pe_weight_d;
            pe_psum_q   <= pe_psum_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign s_ready          = (state_q == FETCH);
    assign result_vld       = (state_q == DONE);
    assign result           = result_q;
    assign pe_data          = pe_data_q;
    assign pe_weight        = pe_weight_q;
    assign pe_psum          = pe_psum_q;
    assign pe_data_update   = upd_q;
    assign pe_weight_update = upd_q;
    assign pe_psum_update   = upd_q;
    assign err              = err_q;

endmodule

// File: tb/tb_pe_driver.sv
// Bench for pe_driver: a 4-cycle-latency MAC PE model, a job table, random
// jobs and hand-written timeout / spurious-result / mid-job-reset sequences.
module tb_pe_driver;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst, start, s_valid;
    logic [7:0]  len, s_data, s_weight;
    logic [15:0] bias;
    logic        busy, s_ready;
    logic [7:0]  pe_data, pe_weight;
    logic [15:0] pe_psum, pe_out_psum, result;
    logic        pe_data_update, pe_weight_update, pe_psum_update;
    logic        pe_out_psum_vld, result_vld, err;

    logic        suppress = 1'b0;
    logic        inject   = 1'b0;
    logic [15:0] inj_val  = 16'h0;
    logic [3:0]  pv       = 4'b0;
    logic [15:0] pd [4];

    int tests = 0, fails = 0;
    int strobe_cnt = 0, rv_cnt = 0, mis = 0;

    typedef struct {
        int n; int b; int d[4]; int w[4];
        int stall; bit spur; bit poke; int exp;
    } vec_t;

    vec_t tbl [5];

    pe_driver #(.WIDTH(8), .LEN_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .busy(busy),
        .s_data(s_data), .s_weight(s_weight), .s_valid(s_valid), .s_ready(s_ready),
        .pe_data(pe_data), .pe_weight(pe_weight), .pe_psum(pe_psum),
        .pe_data_update(pe_data_update), .pe_weight_update(pe_weight_update),
        .pe_psum_update(pe_psum_update), .pe_out_psum(pe_out_psum),
        .pe_out_psum_vld(pe_out_psum_vld), .result(result), .result_vld(result_vld),
        .err(err)
    );

    always #5 clk = ~clk;

    // PE model: result = psum + data*weight, valid 4 cycles after the strobe
    always @(posedge clk) begin
        pv    <= {pv[2:0], pe_psum_update};
        pd[0] <= pe_psum + 16'(pe_data) * 16'(pe_weight);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign pe_out_psum_vld = (pv[3] & ~suppress) | inject;
    assign pe_out_psum     = inject ? inj_val : pd[3];

    always @(negedge clk) begin
        if (pe_data_update) strobe_cnt <= strobe_cnt + 1;
        if (result_vld) rv_cnt <= rv_cnt + 1;
        if ((pe_data_update !== pe_weight_update) || (pe_data_update !== pe_psum_update))
            mis <= mis + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int ref_sum(input vec_t v);
        int s = v.b;
        for (int i = 0; i < v.n; i++) s = s + v.d[i] * v.w[i];
        return s & 16'hFFFF;
    endfunction

    task automatic run_job(input string nm, input vec_t v);
        int s0, r0, t, last_t, guard, mdl;
        bit got;
        mdl = v.b & 16'hFFFF;
        s0 = strobe_cnt; r0 = rv_cnt; t = 0; last_t = 0;
        start = 1'b1; len = v.n[7:0]; bias = v.b[15:0]; s_valid = 1'b0;
        step();
        start = 1'b0;
        chk({nm, "_err_clr"}, err, 0);
        for (int i = 0; i < v.n; i++) begin
            if (i == 0) begin
                for (int k = 0; k < v.stall; k++) begin
                    inject = v.spur && (k == 0);
                    inj_val = 16'hDEAD;
                    step(); t++;
                    inject = 1'b0;
                    chk({nm, "_stall"}, {busy, s_ready, pe_data_update}, 3'b110);
                end
            end
            s_data = v.d[i][7:0]; s_weight = v.w[i][7:0]; s_valid = 1'b1;
            guard = 0; got = 1'b0;
            while (!got && guard < 64) begin
                step(); t++; guard++;
                if (pe_data_update) got = 1'b1;
            end
            chk({nm, "_strobe_seen"}, got, 1);
            chk({nm, "_pe_psum"}, pe_psum, mdl[15:0]);
            chk({nm, "_pe_operands"}, {pe_data, pe_weight}, {v.d[i][7:0], v.w[i][7:0]});
            if (i > 0) chk({nm, "_spacing"}, t - last_t, 6);
            last_t = t;
            mdl = (mdl + v.d[i] * v.w[i]) & 16'hFFFF;
            if (v.poke && i == 0) begin
                start = 1'b1; len = 8'd0; bias = 16'hAAAA;
                step(); t++;
                start = 1'b0;
                chk({nm, "_poke_busy"}, {busy, result_vld}, 2'b10);
            end
        end
        s_valid = 1'b0;
        guard = 0;
        while (!result_vld && guard < 64) begin
            step(); guard++;
        end
        chk({nm, "_rv_seen"}, result_vld, 1);
        chk({nm, "_result"}, result, v.exp[15:0]);
        chk({nm, "_result_model"}, result, mdl[15:0]);
        repeat (3) step();
        chk({nm, "_hold"}, {busy, result}, {1'b0, v.exp[15:0]});
        chk({nm, "_rv_pulses"}, rv_cnt - r0, 1);
        chk({nm, "_strobes"}, strobe_cnt - s0, v.n);
        chk({nm, "_err_end"}, err, v.spur);
    endtask

    initial begin
        vec_t v;
        int guard;
        tbl[0] = '{3, 10,      '{2, 4, 1, 0},     '{3, 5, 1, 0},     0,  1'b0, 1'b0, 37};
        tbl[1] = '{1, 'hFFFF,  '{1, 0, 0, 0},     '{1, 0, 0, 0},     20, 1'b0, 1'b0, 0};
        tbl[2] = '{2, 100,     '{255, 255, 0, 0}, '{255, 255, 0, 0}, 0,  1'b0, 1'b0, 'hFC66};
        tbl[3] = '{2, 7,       '{2, 3, 0, 0},     '{2, 3, 0, 0},     2,  1'b1, 1'b1, 20};
        tbl[4] = '{4, 0,       '{1, 3, 5, 7},     '{2, 4, 6, 8},     0,  1'b0, 1'b0, 100};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; len = 8'd0; bias = 16'd0;
        s_data = 8'd0; s_weight = 8'd0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_ctrl", {busy, s_ready, pe_data_update, pe_weight_update,
                           pe_psum_update, result_vld, err}, 7'b0);
        chk("reset_result", result, 0);
        chk("reset_pe_regs", {pe_data, pe_weight, pe_psum}, 32'b0);

        // zero-length job: DONE on the next cycle, IDLE the one after
        step();
        start = 1'b1; len = 8'd0; bias = 16'h1234;
        step();
        start = 1'b0;
        chk("zero_done", {busy, result_vld, result}, {2'b11, 16'h1234});
        step();
        chk("zero_idle", {busy, result_vld, result}, {2'b00, 16'h1234});
        chk("zero_no_strobe", strobe_cnt, 0);

        for (int i = 0; i < 5; i++) run_job($sformatf("tbl%0d", i), tbl[i]);

        // spurious PE result while idle
        chk("spur_pre_err", err, 0);
        inject = 1'b1; inj_val = 16'hBEEF;
        step();
        inject = 1'b0;
        chk("spur_idle_err", {busy, err}, 2'b01);

        // timeout: PE never answers
        suppress = 1'b1;
        start = 1'b1; len = 8'd1; bias = 16'd5;
        step();
        start = 1'b0;
        s_data = 8'd3; s_weight = 8'd3; s_valid = 1'b1;
        guard = 0;
        while (!pe_data_update && guard < 64) begin step(); guard++; end
        chk("tmo_strobe", pe_data_update, 1);
        s_valid = 1'b0;
        begin
            int r0, n;
            r0 = rv_cnt; n = 0;
            while (busy && n < 64) begin step(); n++; end
            chk("tmo_cycles", n, TO);
            chk("tmo_err", {busy, err}, 2'b01);
            repeat (3) step();
            chk("tmo_err_sticky", err, 1);
            chk("tmo_no_rv", rv_cnt - r0, 0);
        end
        suppress = 1'b0;
        v = tbl[0];
        run_job("after_tmo", v);

        // reset during the WAIT of the second operation
        start = 1'b1; len = 8'd3; bias = 16'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_data = 8'(9 - i); s_weight = 8'(9 - i); s_valid = 1'b1;
            guard = 0;
            do begin step(); guard++; end while (!pe_data_update && guard < 64);
            chk("mid_strobe", pe_data_update, 1);
        end
        s_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ctrl", {busy, s_ready, pe_data_update, pe_weight_update,
                             pe_psum_update, result_vld, err}, 7'b0);
        chk("mid_rst_data", {result, pe_data, pe_weight, pe_psum}, 48'b0);
        guard = 0;
        while (!err && guard < 10) begin step(); guard++; end
        chk("mid_late_vld_err", err, 1);
        repeat (4) step();

        for (int r = 0; r < 6; r++) begin
            v.n = $urandom_range(1, 4);
            v.b = $urandom & 16'hFFFF;
            for (int k = 0; k < 4; k++) begin
                v.d[k] = $urandom_range(0, 255);
                v.w[k] = $urandom_range(0, 255);
            end
            v.stall = $urandom_range(0, 3);
            v.spur = 1'b0; v.poke = 1'b0;
            v.exp = ref_sum(v);
            run_job($sformatf("rnd%0d", r), v);
        end

        chk("strobe_align", mis, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
